// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop synchronizers, optional glitch filter, registered count/dir/step/err.
// Define QUAD_DECODER_FILTER_EN to insert a 3-sample agreement filter ahead of the decoder.
module quad_decoder #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qa,
    input  logic             qb,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

`ifdef QUAD_DECODER_FILTER_EN
    localparam int STAGES = 4;
`else
    localparam int STAGES = 2;
`endif

    logic [1:0]        a_sync, b_sync;
    logic              acc_a, acc_b;
    logic [1:0]        cur, prev;
    logic              init;
    logic [STAGES-1:0] vld_pipe;
    logic [1:0]        delta;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[0], qa};
            b_sync <= {b_sync[0], qb};
        end
    end

`ifdef QUAD_DECODER_FILTER_EN
    logic [1:0] a_hist, b_hist;
    logic       a_hold, b_hold;

    // A phase is accepted once the synchronized sample and the two before it agree.
    always_comb begin
        acc_a = a_hold;
        acc_b = b_hold;
        if (a_sync[1] == a_hist[0] && a_hist[0] == a_hist[1]) acc_a = a_sync[1];
        if (b_sync[1] == b_hist[0] && b_hist[0] == b_hist[1]) acc_b = b_sync[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_hist <= '0;
            b_hist <= '0;
            a_hold <= 1'b0;
            b_hold <= 1'b0;
        end else begin
            a_hist <= {a_hist[0], a_sync[1]};
            b_hist <= {b_hist[0], b_sync[1]};
            a_hold <= acc_a;
            b_hold <= acc_b;
        end
    end
`else
    assign acc_a = a_sync[1];
    assign acc_b = b_sync[1];
`endif

    assign cur = {acc_a, acc_b};

    // Marks when the accepted pair reflects the pins rather than post-reset flop contents.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
    end

    // Gray code to position: the up sequence 00,01,11,10 maps to 0,1,2,3.
    function automatic logic [1:0] pos(input logic [1:0] p);
        case (p)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
    endfunction

    assign delta = pos(cur) - pos(prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            dir   <= 1'b1;
            step  <= 1'b0;
            err   <= 1'b0;
            prev  <= 2'b00;
            init  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (vld_pipe[STAGES-1]) begin
                prev <= cur;
                if (!init) begin
                    init <= 1'b1;
                end else begin
                    case (delta)
                        2'd1: begin
                            count <= count + 1'b1;
                            dir   <= 1'b1;
                            step  <= 1'b1;
                        end
                        2'd3: begin
                            count <= count - 1'b1;
                            dir   <= 1'b0;
                            step  <= 1'b1;
                        end
                        2'd2:    err <= 1'b1;
                        default: ;
                    endcase
                end
            end
            if (clr) begin
                count <= '0;
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (CNT_W=4); inputs driven and outputs sampled on the falling edge.
module tb_quad_decoder;

`ifdef QUAD_DECODER_FILTER_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       qa = 1'b0, qb = 1'b0, clr = 1'b0;
    logic [3:0] count;
    logic       dir, step, err;

    int errors = 0;
    int checks = 0;
    int steps;

    quad_decoder #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .clr(clr),
        .count(count), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step) steps++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; {qa, qb} = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (count !== 4'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
        checks++; if (dir !== 1'b1)   begin errors++; $display("FAIL reset_dir got=%b exp=1", dir); end
        checks++; if (step !== 1'b0)  begin errors++; $display("FAIL reset_step got=%b exp=0", step); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        steps = 0;
        wait_cyc(10);
        checks++; if (steps != 0)     begin errors++; $display("FAIL idle_steps got=%0d exp=0", steps); end
        checks++; if (count !== 4'h0) begin errors++; $display("FAIL idle_count got=%h exp=0", count); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL idle_err got=%b exp=0", err); end
    endtask

    task automatic test_up();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        steps = 0;
        for (int r = 0; r < 5; r++)
            for (int p = 0; p < 4; p++) begin
                {qa, qb} = seq[p];
                wait_cyc(8);
            end
        checks++; if (steps != 20)    begin errors++; $display("FAIL up_steps got=%0d exp=20", steps); end
        checks++; if (count !== 4'h4) begin errors++; $display("FAIL up_count got=%h exp=4", count); end
        checks++; if (dir !== 1'b1)   begin errors++; $display("FAIL up_dir got=%b exp=1", dir); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL up_err got=%b exp=0", err); end
    endtask

    task automatic test_down_wrap();
        int lat;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (count !== 4'h0) begin errors++; $display("FAIL clr_count got=%h exp=0", count); end
        {qa, qb} = 2'b10;
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (step) lat = i;
        end
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL latency got=%0d exp=%0d", lat, EXP_LAT); end
        checks++; if (count !== 4'hF) begin errors++; $display("FAIL down_count got=%h exp=f", count); end
        checks++; if (dir !== 1'b0)   begin errors++; $display("FAIL down_dir got=%b exp=0", dir); end
        steps = 0;
        wait_cyc(6);
        checks++; if (steps != 0)     begin errors++; $display("FAIL step_width extra=%0d exp=0", steps); end
        {qa, qb} = 2'b00;
        wait_cyc(8);
        checks++; if (count !== 4'h0) begin errors++; $display("FAIL wrap_up_count got=%h exp=0", count); end
        checks++; if (dir !== 1'b1)   begin errors++; $display("FAIL wrap_up_dir got=%b exp=1", dir); end
    endtask

    task automatic test_err();
        {qa, qb} = 2'b01;
        wait_cyc(8);
        checks++; if (count !== 4'h1) begin errors++; $display("FAIL pre_err_count got=%h exp=1", count); end
        {qa, qb} = 2'b10;
        steps = 0;
        wait_cyc(8);
        checks++; if (err !== 1'b1)   begin errors++; $display("FAIL err_set got=%b exp=1", err); end
        checks++; if (count !== 4'h1) begin errors++; $display("FAIL err_count got=%h exp=1", count); end
        checks++; if (steps != 0)     begin errors++; $display("FAIL err_steps got=%0d exp=0", steps); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL clr_err got=%b exp=0", err); end
        checks++; if (count !== 4'h0) begin errors++; $display("FAIL clr_err_count got=%h exp=0", count); end
    endtask

    task automatic test_clr_with_step();
        {qa, qb} = 2'b00;
        wait_cyc(8);
        checks++; if (count !== 4'h1) begin errors++; $display("FAIL pre_clr_count got=%h exp=1", count); end
        {qa, qb} = 2'b01;
        repeat (EXP_LAT - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (step !== 1'b1)  begin errors++; $display("FAIL clr_step got=%b exp=1", step); end
        checks++; if (count !== 4'h0) begin errors++; $display("FAIL clr_step_count got=%h exp=0", count); end
        checks++; if (dir !== 1'b1)   begin errors++; $display("FAIL clr_step_dir got=%b exp=1", dir); end
        steps = 0;
        wait_cyc(6);
        checks++; if (steps != 0 || count !== 4'h0) begin
            errors++; $display("FAIL clr_prev_upd steps=%0d count=%h exp=0/0", steps, count);
        end
    endtask

    task automatic test_reset_11();
        rst = 1'b1; {qa, qb} = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        steps = 0;
        wait_cyc(10);
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL r11_err got=%b exp=0", err); end
        checks++; if (steps != 0)     begin errors++; $display("FAIL r11_steps got=%0d exp=0", steps); end
        {qa, qb} = 2'b10;
        wait_cyc(8);
        checks++; if (count !== 4'h1) begin errors++; $display("FAIL r11_count got=%h exp=1", count); end
        checks++; if (dir !== 1'b1)   begin errors++; $display("FAIL r11_dir got=%b exp=1", dir); end
        checks++; if (steps != 1)     begin errors++; $display("FAIL r11_steps2 got=%0d exp=1", steps); end
    endtask

`ifdef QUAD_DECODER_FILTER_EN
    task automatic test_glitch();
        steps = 0;
        {qa, qb} = 2'b11;
        wait_cyc(2);
        {qa, qb} = 2'b10;
        wait_cyc(10);
        checks++; if (steps != 0)     begin errors++; $display("FAIL glitch_steps got=%0d exp=0", steps); end
        checks++; if (count !== 4'h1) begin errors++; $display("FAIL glitch_count got=%h exp=1", count); end
        {qa, qb} = 2'b11;
        wait_cyc(3);
        {qa, qb} = 2'b10;
        wait_cyc(10);
        checks++; if (steps != 2)     begin errors++; $display("FAIL stable3_steps got=%0d exp=2", steps); end
    endtask
`endif

    initial begin
        test_reset();
        test_up();
        test_down_wrap();
        test_err();
        test_clr_with_step();
        test_reset_11();
`ifdef QUAD_DECODER_FILTER_EN
        test_glitch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the position count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port qa, input, 1 bit: quadrature phase A, asynchronous to clk.
REQ-005 The block SHALL have port qb, input, 1 bit: quadrature phase B, asynchronous to clk.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of count and err.
REQ-007 The block SHALL have port count, output, CNT_W bits: the signed-agnostic position count.
REQ-008 The block SHALL have port dir, output, 1 bit: direction of the last valid step (1 = up, 0 = down).
REQ-009 The block SHALL have port step, output, 1 bit: one-cycle pulse per valid step.
REQ-010 The block SHALL have port err, output, 1 bit: sticky flag for illegal transitions (both phases changing).

Function
REQ-011 qa and qb SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 The block SHALL hold the previously accepted phase pair prev = {a,b} and compare it with the current accepted pair cur each cycle.
REQ-013 The up sequence SHALL be 00->01->11->10->00; the opposite sequence SHALL be down.
REQ-014 On an up transition: count <= count+1, dir <= 1, step = 1 for exactly one cycle, prev <= cur.
REQ-015 On a down transition: count <= count-1, dir <= 0, step = 1 for exactly one cycle, prev <= cur.
REQ-016 When cur equals prev, count, dir and prev SHALL be held and step SHALL be 0.
REQ-017 When both bits differ: err <= 1 (sticky), count and dir held, step = 0, prev <= cur.
REQ-018 count SHALL wrap modulo 2^CNT_W: all-ones+1 -> 0; 0-1 -> all-ones.
REQ-019 count, dir, step and err SHALL be registered outputs.
REQ-020 Latency without the filter: a pin change that is first sampled at edge k SHALL produce step/count update visible after edge k+2.
REQ-021 An init flag SHALL be cleared by reset; the first accepted pair after reset SHALL load prev only (no step, no err, count unchanged) and set the init flag.
REQ-022 clr=1 SHALL force count <= 0 and err <= 0 that cycle, taking precedence over any concurrent step or error; step and dir SHALL still reflect a concurrent valid transition, and prev SHALL still update.

Reset
REQ-023 With rst=1 at a rising edge: count=0, dir=1, step=0, err=0, prev=00, init flag cleared, synchronizer and filter flops=0.
REQ-024 rst SHALL take precedence over clr and all transitions; a reset mid-sequence SHALL discard partial filter history.

Configuration
REQ-025 Macro QUAD_DECODER_FILTER_EN SHALL select a glitch filter between synchronizer and decoder.
REQ-026 With QUAD_DECODER_FILTER_EN defined, a phase SHALL be accepted only after 3 consecutive equal synchronized samples, adding 2 cycles of latency (update after edge k+4); shorter pulses SHALL be ignored.
REQ-027 Without QUAD_DECODER_FILTER_EN, synchronized samples SHALL be accepted directly and no filter flops SHALL exist.

Verification
REQ-028 Reset, then {qa,qb}=00 held 10 cycles -> count=0, step never high, err=0.
REQ-029 Drive 00->01->11->10->00 repeated 5 times, 8 cycles per phase -> 20 step pulses, dir=1, count=4 (CNT_W=4, wraps through 0).
REQ-030 From count=0 drive 00->10 -> count=F, dir=0, single step pulse; then 10->00 -> count=0.
REQ-031 Drive 01->10 (both change) -> err=1, count unchanged, no step; assert clr one cycle -> err=0, count=0.
REQ-032 Release reset with {qa,qb}=11 -> no err, no step; then 11->10 -> count=1, dir=1.
REQ-033 With QUAD_DECODER_FILTER_EN: 2-cycle glitch 00->01->00 -> no step; 3-cycle-stable change -> one step, 2 cycles later than unfiltered build.
